countdown_timer: RTL and testbench

- Programmable down-counting timer: accepts a load value over a valid/ready handshake, counts to zero at a prescaled rate, then presents a completion token over a valid/ready handshake.
- Consumer-side complement of the up-counting blocks in lib_rtl.
- Used by control FSMs as timeout/delay generators.

---
 rtl/countdown_timer_pkg.sv | 13 +
 rtl/countdown_timer_tick_prescaler.sv | 24 ++
 rtl/countdown_timer.sv | 119 +++++++++++
 tb/tb_countdown_timer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared state encodings and default widths for countdown_timer.
package countdown_timer_pkg;

  localparam int DEF_NBITS    = 32;
  localparam int DEF_PS_NBITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Free-running divider: tick every max+1 enabled cycles, holds when en=0, clears on clr.
module tick_prescaler #(
  parameter int P_PS_NBITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  input  logic [P_PS_NBITS-1:0] max,
  output logic                  tick
);

  logic [P_PS_NBITS-1:0] cnt;

  assign tick = en && (cnt == max);

  always_ff @(posedge clk) begin
    if (!reset)        cnt <= '0;
    else if (clr)      cnt <= '0;
    else if (tick)     cnt <= '0;
    else if (en)       cnt <= cnt + P_PS_NBITS'(1);
  end

endmodule

// File: rtl/countdown_timer.sv
// Prescaled down-counter with load/done handshakes.
// Optional periodic mode under `COUNTDOWN_AUTORELOAD_EN (adds auto_reload input).
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int P_NBITS    = DEF_NBITS,
  parameter int P_PS_NBITS = DEF_PS_NBITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [P_NBITS-1:0]    load_val,
  input  logic [P_PS_NBITS-1:0] load_prescale,
  input  logic                  load_valid,
  output logic                  load_ready,
`ifdef COUNTDOWN_AUTORELOAD_EN
  input  logic                  auto_reload,
`endif
  input  logic                  pause,
  input  logic                  abort,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic                  expired,
  output logic                  busy,
  output logic [P_NBITS-1:0]    cnt_value
);

  state_t                state;
  logic [P_PS_NBITS-1:0] ps_max;
  logic                  tick, accept, ps_clr, ps_en;
  logic                  do_reload;
  logic [P_NBITS-1:0]    reload_val;

  assign load_ready = (state == ST_IDLE);
  assign busy       = (state == ST_RUN);
  assign accept     = load_valid && load_ready && !abort;
  assign ps_clr     = accept || abort;
  assign ps_en      = busy && !pause && !abort;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic reload_en;
  logic [P_NBITS-1:0] reload_q;
  assign do_reload  = reload_en;
  assign reload_val = reload_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      reload_en <= 1'b0;
      reload_q  <= '0;
    end else if (accept) begin
      reload_en <= auto_reload;
      reload_q  <= load_val;
    end
  end
`else
  assign do_reload  = 1'b0;
  assign reload_val = '0;
`endif

  tick_prescaler #(.P_PS_NBITS(P_PS_NBITS)) u_ps (
    .clk   (clk),
    .reset (reset),
    .clr   (ps_clr),
    .en    (ps_en),
    .max   (ps_max),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt_value  <= '0;
      ps_max     <= '0;
      done_valid <= 1'b0;
      expired    <= 1'b0;
    end else if (abort) begin
      state      <= ST_IDLE;
      cnt_value  <= '0;
      done_valid <= 1'b0;
      expired    <= 1'b0;
    end else begin
      expired <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          ps_max <= load_prescale;
          if (load_val != '0) begin
            cnt_value <= load_val;
            state     <= ST_RUN;
          end else begin
            // zero load skips RUN entirely
            cnt_value  <= '0;
            state      <= ST_DONE;
            done_valid <= 1'b1;
            expired    <= 1'b1;
          end
        end
        ST_RUN: if (tick) begin
          if (cnt_value == P_NBITS'(1)) begin
            expired <= 1'b1;
            if (do_reload) begin
              cnt_value <= reload_val;
            end else begin
              cnt_value  <= '0;
              state      <= ST_DONE;
              done_valid <= 1'b1;
            end
          end else begin
            cnt_value <= cnt_value - P_NBITS'(1);
          end
        end
        ST_DONE: if (done_ready) begin
          state      <= ST_IDLE;
          done_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus queues expected expiry events, monitor checks them.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] load_val;
  logic [7:0]  load_prescale;
  logic        load_valid, load_ready, pause, abort;
  logic        done_valid, done_ready, expired, busy;
  logic [31:0] cnt_value;
`ifdef COUNTDOWN_AUTORELOAD_EN
  logic        auto_reload;
`endif

  countdown_timer dut (
    .clk           (clk),
    .reset         (reset),
    .load_val      (load_val),
    .load_prescale (load_prescale),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
`ifdef COUNTDOWN_AUTORELOAD_EN
    .auto_reload   (auto_reload),
`endif
    .pause         (pause),
    .abort         (abort),
    .done_valid    (done_valid),
    .done_ready    (done_ready),
    .expired       (expired),
    .busy          (busy),
    .cnt_value     (cnt_value)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic        dv;
    logic [31:0] cnt;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every expired pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && expired === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_expired", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_expire_cycle", cyc, e.at);
        chk("sb_done_valid", {31'd0, done_valid}, {31'd0, e.dv});
        chk("sb_cnt", cnt_value, e.cnt);
      end
    end
  end

  task automatic push(input int at, input logic dv, input logic [31:0] c);
    exp_t e;
    e.at = at; e.dv = dv; e.cnt = c;
    sb.push_back(e);
  endtask

  // Issue a load at this negedge; accept edge is the next posedge.
  task automatic load(input logic [31:0] v, input logic [7:0] p, input int extra);
    load_val      = v;
    load_prescale = p;
    load_valid    = 1'b1;
    push(cyc + 1 + ((v == 0) ? 1 : int'(v) * (int'(p) + 1)) - ((v == 0) ? 1 : 0) + extra,
         1'b1, 32'd0);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; load_val = '0; load_prescale = '0; load_valid = 1'b0;
    pause = 1'b0; abort = 1'b0; done_ready = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    auto_reload = 1'b0;
`endif
    step(2);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_valid", {31'd0, done_valid}, 32'd0);
    chk("rst_expired", {31'd0, expired}, 32'd0);
    chk("rst_cnt", cnt_value, 32'd0);
    reset = 1'b1;
    step(1);

    // 5 @ prescale 0, consumer always ready
    done_ready = 1'b1;
    load(32'd5, 8'd0, 0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_cnt0", cnt_value, 32'd5);
    chk("t1_load_ready", {31'd0, load_ready}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step(1);
      chk("t1_cnt", cnt_value, 32'(5 - i));
    end
    chk("t1_done_valid", {31'd0, done_valid}, 32'd1);
    chk("t1_busy_off", {31'd0, busy}, 32'd0);
    step(1);
    chk("t1_ready_back", {31'd0, load_ready}, 32'd1);
    chk("t1_dv_clear", {31'd0, done_valid}, 32'd0);

    // 3 @ prescale 2: decrement every 3rd cycle, DONE after 9
    load(32'd3, 8'd2, 0);
    for (int i = 1; i <= 9; i++) begin
      step(1);
      chk("t2_cnt", cnt_value, 32'(3 - i / 3));
    end
    chk("t2_done_valid", {31'd0, done_valid}, 32'd1);
    step(1);

    // 4 @ prescale 0 with 3-cycle pause; consumer stalls 4 cycles
    done_ready = 1'b0;
    load(32'd4, 8'd0, 3);
    step(1);
    chk("t3_cnt_pre", cnt_value, 32'd3);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t3_paused_cnt", cnt_value, 32'd3);
    end
    pause = 1'b0;
    step(3);
    load_val   = 32'd7;
    load_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("t3_done_hold", {31'd0, done_valid}, 32'd1);
      chk("t3_expired", {31'd0, expired}, (j == 0) ? 32'd1 : 32'd0);
      chk("t3_ready_done", {31'd0, load_ready}, 32'd0);
      if (j < 3) step(1);
    end
    load_valid = 1'b0;
    done_ready = 1'b1;
    step(1);
    chk("t3_idle", {31'd0, load_ready}, 32'd1);
    chk("t3_cnt_idle", cnt_value, 32'd0);

    // zero load goes straight to DONE; loads in DONE ignored
    done_ready = 1'b0;
    load(32'd0, 8'd0, 0);
    chk("t4_dv", {31'd0, done_valid}, 32'd1);
    chk("t4_cnt", cnt_value, 32'd0);
    load_val = 32'd9; load_valid = 1'b1;
    step(2);
    chk("t4_ignored_cnt", cnt_value, 32'd0);
    chk("t4_ignored_rdy", {31'd0, load_ready}, 32'd0);
    load_valid = 1'b0; done_ready = 1'b1;
    step(1);

    // abort in RUN at cnt=2
    load_val = 32'd4; load_prescale = 8'd0; load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
    step(2);
    chk("t5_cnt2", cnt_value, 32'd2);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t5_idle", {31'd0, load_ready}, 32'd1);
    chk("t5_cnt", cnt_value, 32'd0);
    chk("t5_dv", {31'd0, done_valid}, 32'd0);
    step(3);

    // abort in DONE
    done_ready = 1'b0;
    load(32'd0, 8'd0, 0);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t6_idle", {31'd0, load_ready}, 32'd1);
    chk("t6_dv", {31'd0, done_valid}, 32'd0);

    // abort beats a load in IDLE
    load_val = 32'd6; load_valid = 1'b1; abort = 1'b1;
    step(1);
    load_valid = 1'b0; abort = 1'b0;
    chk("t7_not_loaded", {31'd0, busy}, 32'd0);
    chk("t7_cnt", cnt_value, 32'd0);

    // reset mid-RUN
    load_val = 32'd5; load_prescale = 8'd1; load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    chk("t8_busy", {31'd0, busy}, 32'd0);
    chk("t8_ready", {31'd0, load_ready}, 32'd1);
    chk("t8_cnt", cnt_value, 32'd0);
    chk("t8_dv", {31'd0, done_valid}, 32'd0);
    step(12);

`ifdef COUNTDOWN_AUTORELOAD_EN
    // periodic mode: expiry every 3 cycles, never DONE
    begin
      int c0;
      c0 = cyc;
      auto_reload = 1'b1; load_val = 32'd3; load_prescale = 8'd0; load_valid = 1'b1;
      for (int k = 1; k <= 4; k++) push(c0 + 1 + 3 * k, 1'b0, 32'd3);
      step(1);
      load_valid = 1'b0; auto_reload = 1'b0;
      step(12);
      chk("ar_busy", {31'd0, busy}, 32'd1);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      chk("ar_idle", {31'd0, load_ready}, 32'd1);
      chk("ar_dv", {31'd0, done_valid}, 32'd0);
      step(4);
    end
`endif

    chk("sb_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
